// File: rtl/ysyx_22040759_wb_sched_pkg.sv
// Shared constants for the NPC writeback scheduler.
// Register-file geometry and requester IDs used by the scheduler and arbiter.
package ysyx_22040759_wb_sched_pkg;
    localparam int XLEN    = 32;
    localparam int RAW     = 5;
    localparam int NREG    = 32;
    localparam int REQ_EXU = 0;
    localparam int REQ_LSU = 1;
endpackage

// File: rtl/ysyx_22040759_wb_sched_rr_arb2.sv
// Two-input round-robin arbiter with a one-bit last-grant pointer.
// On a conflict the requester that was not granted last time wins.
module ysyx_22040759_rr_arb2
    import ysyx_22040759_wb_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic last;

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Pointer resets to EXU so LSU wins the first conflict.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last <= 1'b0;
        end else if (|gnt) begin
            last <= gnt[REQ_LSU];
        end
    end
endmodule

// File: rtl/ysyx_22040759_wb_sched.sv
// GPR writeback scheduler: shares the single write port between EXU and
// LSU and tracks outstanding writes for RAW/WAW hazard detection.
module ysyx_22040759_wb_sched
    import ysyx_22040759_wb_sched_pkg::*;
#(
    parameter int XW = XLEN,
    parameter int AW = RAW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_rd,
    output logic          iss_ready,
    input  logic [AW-1:0] chk_rs1,
    input  logic [AW-1:0] chk_rs2,
    output logic          haz1,
    output logic          haz2,
    input  logic          exu_valid,
    input  logic [AW-1:0] exu_rd,
    input  logic [XW-1:0] exu_data,
    output logic          exu_ready,
    input  logic          lsu_valid,
    input  logic [AW-1:0] lsu_rd,
    input  logic [XW-1:0] lsu_data,
    output logic          lsu_ready,
    output logic          gpr_wen,
    output logic [AW-1:0] gpr_waddr,
    output logic [XW-1:0] gpr_wdata
);
    localparam int NR = 1 << AW;

    logic [NR-1:0] pend;
    logic [NR-1:0] pend_set;
    logic [NR-1:0] pend_clr;
    logic [1:0]    gnt;
    logic [AW-1:0] sel_rd;
    logic [XW-1:0] sel_data;

    ysyx_22040759_rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({lsu_valid, exu_valid}),
        .gnt (gnt)
    );

    assign exu_ready = gnt[REQ_EXU];
    assign lsu_ready = gnt[REQ_LSU];

    // Decode side sees only registered state.
    assign iss_ready = !pend[iss_rd];
    assign haz1      = pend[chk_rs1];
    assign haz2      = pend[chk_rs2];

    always_comb begin
        sel_rd   = exu_rd;
        sel_data = exu_data;
        if (gnt[REQ_LSU]) begin
            sel_rd   = lsu_rd;
            sel_data = lsu_data;
        end
    end

    always_comb begin
        pend_set = '0;
        pend_clr = '0;
        if (iss_valid && iss_ready && iss_rd != '0) begin
            pend_set = NR'(1) << iss_rd;
        end
        if (gpr_wen) begin
            pend_clr = NR'(1) << gpr_waddr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend      <= '0;
            gpr_wen   <= 1'b0;
            gpr_waddr <= '0;
            gpr_wdata <= '0;
        end else begin
            pend    <= ((pend & ~pend_clr) | pend_set) & ~NR'(1);
            gpr_wen <= (|gnt) && (sel_rd != '0);
            if (|gnt) begin
                gpr_waddr <= sel_rd;
                gpr_wdata <= sel_data;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_22040759_wb_sched.sv
// Randomized bench for the writeback scheduler against a behavioural model.
// Directed scenarios first, then a long random run with sporadic resets.
module tb_ysyx_22040759_wb_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_ready;
    logic [4:0]  chk_rs1, chk_rs2;
    logic        haz1, haz2;
    logic        exu_valid, lsu_valid;
    logic [4:0]  exu_rd, lsu_rd;
    logic [31:0] exu_data, lsu_data;
    logic        exu_ready, lsu_ready;
    logic        gpr_wen;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;

    always #5 clk = ~clk;

    ysyx_22040759_wb_sched dut (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .chk_rs1   (chk_rs1),
        .chk_rs2   (chk_rs2),
        .haz1      (haz1),
        .haz2      (haz2),
        .exu_valid (exu_valid),
        .exu_rd    (exu_rd),
        .exu_data  (exu_data),
        .exu_ready (exu_ready),
        .lsu_valid (lsu_valid),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .lsu_ready (lsu_ready),
        .gpr_wen   (gpr_wen),
        .gpr_waddr (gpr_waddr),
        .gpr_wdata (gpr_wdata)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: set of outstanding registers, who won last,
    // and the write the GPR port should show this cycle.
    bit          pm[32];
    bit          lm;
    bit          ew;
    logic [4:0]  ea;
    logic [31:0] ed;

    // Producer state: held until accepted.
    bit          e_v, l_v;
    logic [4:0]  e_rd, l_rd;
    logic [31:0] e_d, l_d;
    bit          saw_l;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        foreach (pm[i]) pm[i] = 1'b0;
        lm = 1'b0;
        ew = 1'b0;
        ea = '0;
        ed = '0;
    endtask

    // Runs one cycle: inputs set at the negedge, checks, then the edge.
    task automatic cycle();
        bit ge, gl, fire;
        logic [4:0] wr;
        logic [31:0] wd;
        exu_valid = e_v; exu_rd = e_rd; exu_data = e_d;
        lsu_valid = l_v; lsu_rd = l_rd; lsu_data = l_d;
        #1;
        ge = e_v && (!l_v || lm);
        gl = l_v && (!e_v || !lm);
        fire = iss_valid && !pm[iss_rd] && iss_rd != 0;
        check("iss_ready", iss_ready, !pm[iss_rd]);
        check("haz1", haz1, pm[chk_rs1]);
        check("haz2", haz2, pm[chk_rs2]);
        check("exu_ready", exu_ready, ge);
        check("lsu_ready", lsu_ready, gl);
        check("gpr_wen", gpr_wen, ew);
        if (ew) begin
            check("gpr_waddr", gpr_waddr, ea);
            check("gpr_wdata", gpr_wdata, ed);
        end
        saw_l = lsu_ready;
        wr = gl ? l_rd : e_rd;
        wd = gl ? l_d : e_d;
        if (!rst) begin
            model_reset();
        end else begin
            if (ew) pm[ea] = 1'b0;
            if (fire) pm[iss_rd] = 1'b1;
            if (ge || gl) begin
                lm = gl;
                ea = wr;
                ed = wd;
            end
            ew = (ge || gl) && wr != 0;
        end
        if (ge) e_v = 1'b0;
        if (gl) l_v = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        iss_valid = 1'b0;
        iss_rd = '0;
        chk_rs1 = '0;
        chk_rs2 = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;
    endtask

    initial begin
        bit [3:0] seq;
        rst = 1'b0;
        idle_inputs();
        e_v = 1'b1; e_rd = 5'd1; e_d = 32'h11;
        l_v = 1'b1; l_rd = 5'd2; l_d = 32'h22;
        iss_valid = 1'b1; iss_rd = 5'd3;
        model_reset();
        @(negedge clk);

        // Reset with all valids high.
        cycle();
        cycle();
        rst = 1'b1;
        e_v = 1'b0; l_v = 1'b0;
        idle_inputs();
        exu_valid = 1'b0; lsu_valid = 1'b0;
        #1;
        check("rst_wen", gpr_wen, 1'b0);
        check("rst_waddr", gpr_waddr, 5'd0);
        check("rst_wdata", gpr_wdata, 32'd0);
        for (int r = 0; r < 32; r++) begin
            chk_rs1 = 5'(r); chk_rs2 = 5'(r); iss_rd = 5'(r);
            #1;
            check("rst_haz1", haz1, 1'b0);
            check("rst_haz2", haz2, 1'b0);
            check("rst_iss_ready", iss_ready, 1'b1);
        end
        idle_inputs();
        @(negedge clk);

        // Issue x5, EXU writes x5 a cycle later.
        iss_valid = 1'b1; iss_rd = 5'd5;
        cycle();
        idle_inputs();
        chk_rs1 = 5'd5;
        e_v = 1'b1; e_rd = 5'd5; e_d = 32'h1234;
        #1 check("x5_haz_c1", haz1, 1'b1);
        cycle();
        check("x5_wen_c2", gpr_wen, 1'b1);
        check("x5_wdata_c2", gpr_wdata, 32'h1234);
        cycle();
        check("x5_haz_c3", haz1, 1'b0);
        cycle();

        // WAW on x7.
        iss_valid = 1'b1; iss_rd = 5'd7;
        cycle();
        check("waw_blocked", iss_ready, 1'b0);
        cycle();
        iss_valid = 1'b0;
        e_v = 1'b1; e_rd = 5'd7; e_d = 32'h77;
        cycle();
        cycle();
        check("waw_open", iss_ready, 1'b1);
        cycle();

        // Conflict after reset: L,E,L,E.
        do_reset();
        idle_inputs();
        e_v = 1'b1; e_rd = 5'd1; e_d = 32'hE1;
        l_v = 1'b1; l_rd = 5'd2; l_d = 32'hA2;
        seq = '0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            seq[3-k] = saw_l;
            if (!e_v) begin e_v = 1'b1; e_rd = 5'(3 + k); end
            if (!l_v) begin l_v = 1'b1; l_rd = 5'(3 + k); end
        end
        e_v = 1'b0; l_v = 1'b0;
        check("conflict_order", seq, 4'b1010);
        cycle();
        cycle();

        // x0 issue and LSU write to x0.
        iss_valid = 1'b1; iss_rd = 5'd0; chk_rs1 = 5'd0;
        l_v = 1'b1; l_rd = 5'd0; l_d = 32'hFFFF;
        cycle();
        idle_inputs();
        cycle();
        check("x0_wen", gpr_wen, 1'b0);
        cycle();

        // Mid-operation reset with x3, x9 pending and a grant in flight.
        iss_valid = 1'b1; iss_rd = 5'd3;
        cycle();
        iss_rd = 5'd9;
        cycle();
        idle_inputs();
        e_v = 1'b1; e_rd = 5'd3; e_d = 32'h33;
        cycle();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        chk_rs1 = 5'd3; chk_rs2 = 5'd9;
        #1;
        check("mid_wen", gpr_wen, 1'b0);
        check("mid_haz3", haz1, 1'b0);
        check("mid_haz9", haz2, 1'b0);
        cycle();

        // Random traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            if (!e_v && $urandom_range(1) == 1) begin
                e_v = 1'b1;
                e_rd = 5'($urandom_range(7));
                e_d = $urandom;
            end
            if (!l_v && $urandom_range(1) == 1) begin
                l_v = 1'b1;
                l_rd = 5'($urandom_range(7));
                l_d = $urandom;
            end
            iss_valid = 1'($urandom_range(1));
            iss_rd = 5'($urandom_range(7));
            chk_rs1 = 5'($urandom_range(7));
            chk_rs2 = 5'($urandom_range(31));
            rst = ($urandom_range(59) != 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
